mbr_mem_if: RTL and testbench

Parametrised memory buffer register with a built-in memory handshake. It is the successor to the fixed 16-bit, strobe-only MBR.
- Holds the CPU data word exchanged with memory.
- Loads from ACC or PC with defined priority.
- Runs read and write transactions through a req/ack protocol with a timeout, and reports busy, done and error status to the control unit.

Sits between the datapath (ACC, PC) and the memory port.

---
 rtl/mbr_pkg.sv | 24 ++
 rtl/mbr_timeout.sv | 34 +++
 rtl/mbr_mem_if.sv | 111 +++++++++++
 tb/tb_mbr_mem_if.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mbr_pkg.sv
// Shared types for the memory buffer register: FSM state encoding and the
// load-source priority used when ACC and PC loads collide.
package mbr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ACC  = 2'd1,
        SRC_PC   = 2'd2
    } load_src_e;

    // ACC outranks PC when both loads are requested in the same cycle.
    function automatic load_src_e pick_src(input logic ld_acc, input logic ld_pc);
        if (ld_acc)     return SRC_ACC;
        else if (ld_pc) return SRC_PC;
        else            return SRC_NONE;
    endfunction

endpackage

// File: rtl/mbr_timeout.sv
// Wait-state counter for one memory transaction; expire flags the edge at
// which the transaction has waited TIMEOUT cycles without an ack.
module mbr_timeout #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    // The counter value before the edge is k-1 at edge N+k, so expiry is
    // reached when it would step onto TIMEOUT.
    assign expire = (count == LAST);

endmodule

// File: rtl/mbr_mem_if.sv
// Memory buffer register with req/ack memory handshake, timeout and status.
// All state changes on the falling edge of clk; rst is async active-low.
module mbr_mem_if
    import mbr_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int PC_W        = 8,
    parameter int PC_ZERO_EXT = 0,
    parameter int TIMEOUT     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_acc,
    input  logic              ld_pc,
    input  logic              rd_start,
    input  logic              wr_start,
    input  logic [DATA_W-1:0] acc_num,
    input  logic [PC_W-1:0]   pc_num,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] buffer_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [DATA_W-1:0] PC_MASK = ~({DATA_W{1'b1}} << PC_W);

    state_e            state;
    logic              expire;
    logic [DATA_W-1:0] pc_ext;
    logic [DATA_W-1:0] pc_load;

    assign pc_ext  = DATA_W'(pc_num);
    assign pc_load = (PC_ZERO_EXT != 0) ? pc_ext : ((buffer_out & ~PC_MASK) | pc_ext);

    mbr_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == IDLE),
        .en     ((state != IDLE) && !mem_ack),
        .expire (expire)
    );

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_wdata  <= '0;
            buffer_out <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    case (pick_src(ld_acc, ld_pc))
                        SRC_ACC: buffer_out <= acc_num;
                        SRC_PC:  buffer_out <= pc_load;
                        default: ;
                    endcase
                    // Snapshot reads the pre-edge buffer, so a same-cycle load
                    // never leaks into the write data.
                    if (rd_start) begin
                        state  <= RD_WAIT;
                        mem_rd <= 1'b1;
                        busy   <= 1'b1;
                        err    <= 1'b0;
                    end else if (wr_start) begin
                        state     <= WR_WAIT;
                        mem_wr    <= 1'b1;
                        mem_wdata <= buffer_out;
                        busy      <= 1'b1;
                        err       <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (mem_ack || expire) begin
                        if (mem_ack) buffer_out <= mem_rdata;
                        else         err        <= 1'b1;
                        state  <= IDLE;
                        mem_rd <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                WR_WAIT: begin
                    if (mem_ack || expire) begin
                        if (!mem_ack) err <= 1'b1;
                        state  <= IDLE;
                        mem_wr <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mbr_mem_if.sv
// Self-checking bench for mbr_mem_if: transaction-level reference model,
// per-cycle compare on the rising edge, directed literal checks, random traffic.
module tb_mbr_mem_if;

    localparam int DATA_W      = 16;
    localparam int PC_W        = 8;
    localparam int PC_ZERO_EXT = 0;
    localparam int TIMEOUT     = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ld_acc = 1'b0, ld_pc = 1'b0, rd_start = 1'b0, wr_start = 1'b0;
    logic [DATA_W-1:0] acc_num = '0;
    logic [PC_W-1:0]   pc_num = '0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic              mem_rd, mem_wr, busy, done, err;
    logic [DATA_W-1:0] mem_wdata, buffer_out;

    int n_checks = 0;
    int n_pass   = 0;

    mbr_mem_if #(
        .DATA_W(DATA_W), .PC_W(PC_W), .PC_ZERO_EXT(PC_ZERO_EXT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .ld_acc(ld_acc), .ld_pc(ld_pc), .rd_start(rd_start), .wr_start(wr_start),
        .acc_num(acc_num), .pc_num(pc_num),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .buffer_out(buffer_out), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a transaction is open from its start edge; it closes on
    // ack, or as an error once TIMEOUT edges have elapsed since the start.
    logic              m_open = 1'b0, m_is_rd = 1'b0, m_done = 1'b0, m_err = 1'b0;
    logic [DATA_W-1:0] m_buf = '0, m_wdata = '0;
    int                edge_no = 0, start_edge = 0;

    function automatic logic [DATA_W-1:0] pc_merge(input logic [DATA_W-1:0] b, input logic [PC_W-1:0] p);
        logic [DATA_W-1:0] hi;
        hi = (b >> PC_W) << PC_W;
        return (PC_ZERO_EXT != 0) ? DATA_W'(p) : (hi | DATA_W'(p));
    endfunction

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            m_open = 1'b0; m_is_rd = 1'b0; m_done = 1'b0; m_err = 1'b0;
            m_buf = '0; m_wdata = '0;
        end else begin
            edge_no++;
            m_done = 1'b0;
            if (!m_open) begin
                if (rd_start || wr_start) begin
                    m_open = 1'b1; m_is_rd = rd_start; start_edge = edge_no; m_err = 1'b0;
                    if (!rd_start) m_wdata = m_buf;
                end
                if (ld_acc)     m_buf = acc_num;
                else if (ld_pc) m_buf = pc_merge(m_buf, pc_num);
            end else if (mem_ack) begin
                if (m_is_rd) m_buf = mem_rdata;
                m_open = 1'b0; m_done = 1'b1;
            end else if (edge_no - start_edge == TIMEOUT) begin
                m_open = 1'b0; m_done = 1'b1; m_err = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        check("mem_rd", 32'(mem_rd), 32'(m_open && m_is_rd));
        check("mem_wr", 32'(mem_wr), 32'(m_open && !m_is_rd));
        check("busy", 32'(busy), 32'(m_open));
        check("done", 32'(done), 32'(m_done));
        check("err", 32'(err), 32'(m_err));
        check("buffer_out", 32'(buffer_out), 32'(m_buf));
        if (m_open && !m_is_rd) check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    end

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rd_high;
        int ack_pct;
        #1 rst = 1'b0;

        // Reset held, then ACC load.
        repeat (3) tick();
        check("rst_buffer", 32'(buffer_out), 32'h0000);
        check("rst_status", {29'd0, busy, done, err}, 32'd0);
        rst = 1'b1;
        ld_acc = 1'b1; acc_num = 16'hBEEF;
        tick();
        check("acc_load", 32'(buffer_out), 32'hBEEF);

        // PC load, then ACC-over-PC priority.
        acc_num = 16'h12FF;
        tick();
        ld_acc = 1'b0; ld_pc = 1'b1; pc_num = 8'h34;
        tick();
        check("pc_load", 32'(buffer_out), (PC_ZERO_EXT != 0) ? 32'h0034 : 32'h1234);
        ld_acc = 1'b1; acc_num = 16'h5555;
        tick();
        check("acc_over_pc", 32'(buffer_out), 32'h5555);
        ld_acc = 1'b0; ld_pc = 1'b0;

        // Read with three wait states and an ignored mid-wait load.
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        rd_high = int'(mem_rd);
        ld_acc = 1'b1; acc_num = 16'hFFFF;
        tick();
        rd_high += int'(mem_rd);
        check("rd_frozen", 32'(buffer_out), 32'h5555);
        ld_acc = 1'b0;
        tick();
        rd_high += int'(mem_rd);
        mem_ack = 1'b1; mem_rdata = 16'hA5A5;
        tick();
        check("rd_high_cycles", 32'(rd_high), 32'd3);
        check("rd_data", 32'(buffer_out), 32'hA5A5);
        check("rd_done", {30'd0, done, mem_rd}, 32'b10);
        mem_ack = 1'b0;
        tick();
        check("rd_done_pulse", 32'(done), 32'd0);

        // Write snapshot taken before a same-cycle ACC load.
        ld_acc = 1'b1; acc_num = 16'h1111;
        tick();
        wr_start = 1'b1; acc_num = 16'h2222;
        tick();
        wr_start = 1'b0; ld_acc = 1'b0;
        check("wr_req", {30'd0, mem_wr, mem_rd}, 32'b10);
        check("wr_snapshot0", 32'(mem_wdata), 32'h1111);
        check("wr_buffer", 32'(buffer_out), 32'h2222);
        tick();
        check("wr_snapshot1", 32'(mem_wdata), 32'h1111);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("wr_done", {30'd0, done, mem_wr}, 32'b10);
        check("wr_buffer_after", 32'(buffer_out), 32'h2222);

        // Timeout with no ack, err clearing, and ack exactly on the timeout edge.
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        repeat (TIMEOUT - 1) tick();
        check("to_pending", {30'd0, busy, err}, 32'b10);
        tick();
        check("to_err", {29'd0, busy, done, err}, 32'b011);
        check("to_buffer", 32'(buffer_out), 32'h2222);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        check("err_cleared", 32'(err), 32'd0);
        repeat (TIMEOUT - 1) tick();
        mem_ack = 1'b1; mem_rdata = 16'h0F0F;
        tick();
        mem_ack = 1'b0;
        check("ack_at_timeout", {29'd0, busy, done, err}, 32'b010);
        check("ack_at_timeout_data", 32'(buffer_out), 32'h0F0F);

        // Simultaneous starts, then async reset while waiting.
        tick();
        rd_start = 1'b1; wr_start = 1'b1;
        tick();
        rd_start = 1'b0; wr_start = 1'b0;
        check("conflict", {30'd0, mem_rd, mem_wr}, 32'b10);
        tick();
        rst = 1'b0;
        #1;
        check("async_rst", {13'd0, mem_rd, busy, done, buffer_out}, 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("no_done_after_rst", 32'(done), 32'd0);

        // Random traffic; slow-ack phases exercise timeouts.
        for (int i = 0; i < 3000; i++) begin
            ack_pct   = ((i / 500) % 2 == 0) ? 35 : 4;
            ld_acc    = ($urandom_range(99) < 20);
            ld_pc     = ($urandom_range(99) < 20);
            rd_start  = ($urandom_range(99) < 15);
            wr_start  = ($urandom_range(99) < 15);
            acc_num   = DATA_W'($urandom);
            pc_num    = PC_W'($urandom);
            mem_rdata = DATA_W'($urandom);
            mem_ack   = ($urandom_range(99) < ack_pct);
            if ($urandom_range(599) == 0) rst = 1'b0;
            else                         rst = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
